// File: rtl/green_walker_pkg.sv
// Shared types and light encodings for the crossing controller.
// Phase codes, one-hot {red,yellow,green} constants, phase-to-light map.
package green_walker_pkg;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_RED    = 2'd2,
        PH_WALK   = 2'd3
    } phase_t;

    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b100;

    function automatic logic [2:0] phase_light(phase_t p);
        logic [2:0] l;
        unique case (p)
            PH_GREEN:  l = LIGHT_GREEN;
            PH_YELLOW: l = LIGHT_YELLOW;
            default:   l = LIGHT_RED;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/walk_phase_scheduler_sec_tick_gen.sv
// sec_tick_gen: 1 Hz prescaler counting 0..CLK_HZ-1 while enabled.
// Ports: clk, rst (async high), enable, clear -> tick (comb), count.
module sec_tick_gen
    import green_walker_pkg::*;
#(
    parameter  int CLK_HZ = 25_000_000,
    localparam int CW     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          clear,
    output logic          tick,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable)
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tick  = enable && (cnt_q == LAST);
    assign count = cnt_q;

endmodule

// File: rtl/walk_phase_scheduler.sv
// Crossing phase sequencer: GREEN->YELLOW->RED->(WALK)->GREEN, 1 s countdown.
// Ports: clk, rst, enable, ped_req -> ped_ack, car_light, walk, phase,
// cur_sec, tick. Optional macro WALK_FLASH_EN flashes walk in last 3 s.
module walk_phase_scheduler
    import green_walker_pkg::*;
#(
    parameter int CLK_HZ     = 25_000_000,
    parameter int GREEN_SEC  = 9,
    parameter int YELLOW_SEC = 3,
    parameter int RED_SEC    = 1,
    parameter int WALK_SEC   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic [2:0] car_light,
    output logic       walk,
    output logic [1:0] phase,
    output logic [3:0] cur_sec,
    output logic       tick
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    if (CLK_HZ < 2 ||
        GREEN_SEC  < 1 || GREEN_SEC  > 9 ||
        YELLOW_SEC < 1 || YELLOW_SEC > 9 ||
        RED_SEC    < 1 || RED_SEC    > 9 ||
        WALK_SEC   < 1 || WALK_SEC   > 9) begin : g_bad_param
        $error("walk_phase_scheduler: illegal CLK_HZ or duration");
    end

    function automatic logic [3:0] dur(phase_t p);
        logic [3:0] d;
        unique case (p)
            PH_GREEN:  d = 4'(GREEN_SEC);
            PH_YELLOW: d = 4'(YELLOW_SEC);
            PH_RED:    d = 4'(RED_SEC);
            default:   d = 4'(WALK_SEC);
        endcase
        return d;
    endfunction

    phase_t        state_q, state_d;
    logic [3:0]    sec_q, sec_d;
    logic          pend_q, pend_d;
    logic [2:0]    light_q, light_d;
    logic          walk_q, walk_d;
    logic          ack_q, ack_d;
    logic [CW-1:0] pre_cnt;
    logic          expire;
    logic          enter_walk;

    sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .clear  (expire),
        .tick   (tick),
        .count  (pre_cnt)
    );

    // A request on the red expiry cycle itself still earns a walk.
    assign expire     = tick && (sec_q == 4'd1);
    assign enter_walk = expire && (state_q == PH_RED) && (pend_q || ped_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PH_GREEN;
            sec_q   <= 4'(GREEN_SEC);
            pend_q  <= 1'b0;
            light_q <= LIGHT_GREEN;
            walk_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            pend_q  <= pend_d;
            light_q <= light_d;
            walk_q  <= walk_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (expire) begin
            unique case (state_q)
                PH_GREEN:  state_d = PH_YELLOW;
                PH_YELLOW: state_d = PH_RED;
                PH_RED:    state_d = enter_walk ? PH_WALK : PH_GREEN;
                default:   state_d = PH_GREEN;
            endcase
        end
    end

    always_comb begin
        sec_d = sec_q;
        if (expire)
            sec_d = dur(state_d);
        else if (tick)
            sec_d = sec_q - 4'd1;
        // Entering walk clears pending and absorbs a same-cycle request.
        pend_d = pend_q;
        if (enter_walk)
            pend_d = 1'b0;
        else if (ped_req && state_q != PH_WALK)
            pend_d = 1'b1;
    end

    always_comb begin
        light_d = phase_light(state_d);
        walk_d  = (state_d == PH_WALK);
        ack_d   = enter_walk;
    end

`ifdef WALK_FLASH_EN
    assign walk = walk_q &&
                  !((sec_q <= 4'd3) && (pre_cnt >= CW'(CLK_HZ / 2)));
`else
    logic unused_cnt;
    assign unused_cnt = ^pre_cnt;
    assign walk       = walk_q;
`endif

    assign ped_ack   = ack_q;
    assign car_light = light_q;
    assign phase     = state_q;
    assign cur_sec   = sec_q;

endmodule

// File: tb/tb_walk_phase_scheduler.sv
// Scoreboard bench for walk_phase_scheduler with CLK_HZ = 10.
// Stimulus queues expected per-tick records; a monitor checks each tick.
module tb_walk_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       ped_req = 1'b0;
    logic       ped_ack;
    logic [2:0] car_light;
    logic       walk;
    logic [1:0] phase;
    logic [3:0] cur_sec;
    logic       tick;

`ifdef WALK_FLASH_EN
    localparam bit FLASH = 1'b1;
`else
    localparam bit FLASH = 1'b0;
`endif

    typedef struct {
        logic [1:0] ph;
        logic [3:0] sec;
        logic [2:0] light;
        logic       wk;
        int         gap;
    } rec_t;

    rec_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   gap = 0;
    int   ack_cnt = 0;

    walk_phase_scheduler #(
        .CLK_HZ(10), .GREEN_SEC(9), .YELLOW_SEC(3),
        .RED_SEC(1), .WALK_SEC(6)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .ped_req(ped_req),
        .ped_ack(ped_ack), .car_light(car_light), .walk(walk),
        .phase(phase), .cur_sec(cur_sec), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic push_run(input logic [1:0] ph, input int hi,
                            input int lo, input int gap0);
        rec_t r;
        for (int s = hi; s >= lo; s--) begin
            r.ph    = ph;
            r.sec   = 4'(s);
            r.light = (ph == 2'd0) ? 3'b001 :
                      (ph == 2'd1) ? 3'b010 : 3'b100;
            r.wk    = (ph == 2'd3) && !(FLASH && s <= 3);
            r.gap   = (s == hi) ? gap0 : 10;
            sbq.push_back(r);
        end
    endtask

    task automatic push_cycle(input bit with_walk);
        push_run(2'd0, 9, 1, 10);
        push_run(2'd1, 3, 1, 10);
        push_run(2'd2, 1, 1, 10);
        if (with_walk)
            push_run(2'd3, 6, 1, 10);
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic wait_at(input logic [1:0] ph, input logic [3:0] s,
                           input int budget);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < budget) begin
            @(posedge clk); #1;
            n++;
            hit = (phase == ph) && (cur_sec == s);
        end
        chk("wait_state_timeout", int'(hit), 1);
    endtask

    task automatic pulse_req();
        ped_req = 1'b1;
        @(posedge clk); #1;
        ped_req = 1'b0;
    endtask

    // Monitor: one scoreboard record per tick; walk flash checked per cycle.
    always @(negedge clk) begin
        rec_t e;
        if (rst) begin
            gap = 0;
        end else begin
            gap++;
            if (ped_ack)
                ack_cnt++;
            if (FLASH && phase == 2'd3)
                chk("walk_flash", int'(walk),
                    int'(cur_sec > 4'd3 || (gap - 1) < 5));
            if (tick) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_tick", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("tick_phase", int'(phase), int'(e.ph));
                    chk("tick_sec", int'(cur_sec), int'(e.sec));
                    chk("tick_light", int'(car_light), int'(e.light));
                    chk("tick_walk", int'(walk), int'(e.wk));
                    chk("tick_gap", gap, e.gap);
                end
                gap = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_phase", int'(phase), 0);
        chk("rst_sec", int'(cur_sec), 9);
        chk("rst_light", int'(car_light), 1);
        chk("rst_walk", int'(walk), 0);
        chk("rst_ack", int'(ped_ack), 0);
        chk("rst_tick", int'(tick), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Plain cycle, no requests.
        push_cycle(1'b0);
        wait_empty(300);
        chk("s1_ack", ack_cnt, 0);

        // One-cycle request in green at 5 s.
        push_cycle(1'b1);
        wait_at(2'd0, 4'd5, 100);
        pulse_req();
        wait_empty(300);
        chk("s2_ack", ack_cnt, 1);
        chk("s2_phase", int'(phase), 0);
        chk("s2_sec", int'(cur_sec), 9);

        // Request held through the whole walk: exactly one walk.
        ped_req = 1'b1;
        push_cycle(1'b1);
        wait_empty(300);
        ped_req = 1'b0;
        push_cycle(1'b0);
        push_run(2'd0, 9, 9, 10);
        wait_empty(300);
        chk("s3_ack", ack_cnt, 2);

        // Freeze 25 cycles in yellow at 2 s.
        push_run(2'd0, 8, 1, 10);
        push_run(2'd1, 3, 3, 10);
        push_run(2'd1, 2, 2, 35);
        push_run(2'd1, 1, 1, 10);
        push_run(2'd2, 1, 1, 10);
        wait_at(2'd1, 4'd2, 200);
        enable = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            chk("frz_sec", int'(cur_sec), 2);
            chk("frz_tick", int'(tick), 0);
        end
        enable = 1'b1;
        wait_empty(200);
        chk("s4_ack", ack_cnt, 2);

        // Reset in walk at 4 s.
        push_cycle(1'b0);
        push_run(2'd3, 6, 5, 10);
        wait_at(2'd0, 4'd5, 100);
        pulse_req();
        wait_empty(300);
        chk("s5_ack", ack_cnt, 3);
        chk("s5_phase", int'(phase), 3);
        chk("s5_sec", int'(cur_sec), 4);
        #3 rst = 1'b1;
        #1;
        chk("mrst_light", int'(car_light), 1);
        chk("mrst_walk", int'(walk), 0);
        chk("mrst_sec", int'(cur_sec), 9);
        chk("mrst_phase", int'(phase), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        push_cycle(1'b0);
        push_run(2'd0, 9, 9, 10);
        wait_empty(300);
        chk("s5b_ack", ack_cnt, 3);

        // Reset discards a pending request.
        pulse_req();
        #3 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        push_cycle(1'b0);
        push_run(2'd0, 9, 9, 10);
        wait_empty(300);
        chk("s6_ack", ack_cnt, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/walk_phase_scheduler.md
# walk_phase_scheduler

Sequences the crossing's car lights and pedestrian WALK signal by repeatedly loading and running a single one-second countdown, one phase at a time. Owns the 1 Hz prescaler and the 4-bit seconds countdown that drives the 7-segment display. Latches pedestrian button requests and grants them at the end of each red phase. Sits between the debounced button inputs and the light/display drivers in the top level.

## Interface
- CLK_HZ, 25_000_000, clock cycles per second tick (≥2)
- GREEN_SEC, 9, green phase length in seconds (1–9)
- YELLOW_SEC, 3, yellow phase length in seconds (1–9)
- RED_SEC, 1, all-red phase length in seconds (1–9)
- WALK_SEC, 6, walk phase length in seconds (1–9)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  1 = run; 0 = freeze prescaler and countdown
- ped_req  in  1  pedestrian request, level, sampled every cycle
- ped_ack  out  1  one-cycle pulse on the cycle WALK is entered
- car_light  out  3  {red,yellow,green}, one-hot
- walk  out  1  pedestrian WALK lamp
- phase  out  2  current phase code
- cur_sec  out  4  seconds remaining in current phase (binary, 1–9)
- tick  out  1  one-cycle pulse at each second boundary

## Operation
- States: PH_GREEN → PH_YELLOW → PH_RED → (pending ? PH_WALK : PH_GREEN); PH_WALK → PH_GREEN.
- Phase entry: cur_sec loads that phase's duration; prescaler clears to 0.
- On tick, if cur_sec > 1: cur_sec decrements. If cur_sec == 1: transition and load the next phase's duration. Each phase therefore lasts exactly N×CLK_HZ enabled cycles.
- Lights: GREEN → 001, YELLOW → 010, RED and WALK → 100. walk = 1 only in PH_WALK.
- Pending flag:
  - Set when ped_req = 1 in any state other than PH_WALK.
  - Cleared on the cycle PH_WALK is entered. A ped_req on that same cycle is absorbed (served by this walk).
  - ped_req during PH_WALK is ignored.
- Pending is evaluated at the RED expiry tick. A request arriving on that exact cycle counts.
- enable = 0 holds prescaler, cur_sec and state. tick stays 0. Pending still latches.
- Any duration parameter outside 1–9, or CLK_HZ < 2, is an elaboration error.

## Timing
- Reset values: state PH_GREEN, cur_sec = GREEN_SEC, prescaler 0, pending 0, car_light = 001, walk 0, ped_ack 0, tick 0, phase = 0.
- Reset mid-phase returns immediately to these values and discards pending.
- Prescaler counts 0..CLK_HZ−1 while enabled. tick is asserted combinationally from the registered count == CLK_HZ−1 && enable.
- State, cur_sec, car_light, walk, phase and ped_ack all update on the clock edge ending the tick cycle, so they are visible 1 cycle after tick.
- All outputs are registered except tick.
- First tick after reset occurs in cycle CLK_HZ−1, counting the first cycle after reset release as 0.

## Configuration
- WALK_FLASH_EN defined: during PH_WALK with cur_sec ≤ 3, walk is low whenever prescaler ≥ CLK_HZ/2 (integer division), giving a 1 Hz flash. It remains high otherwise.
- WALK_FLASH_EN undefined: walk is steady 1 for the whole PH_WALK. No flash logic is synthesized.

## Structure
- Shared package green_walker_pkg:
  - phase_t encoding: PH_GREEN = 0, PH_YELLOW = 1, PH_RED = 2, PH_WALK = 3.
  - Light constants LIGHT_GREEN = 3'b001, LIGHT_YELLOW = 3'b010, LIGHT_RED = 3'b100.
- Sub-module sec_tick_gen holds the prescaler.
  - Inputs: clk, rst, enable, clear.
  - Outputs: tick and count (count is used by the flash logic).
- The FSM, countdown and pending latch live in the top module.

## Test plan
- Bench setting: CLK_HZ = 10, default durations.
- Reset, then no requests → green 90 cycles, yellow 30, red 10, back to green; cur_sec reads 9..1, then 3..1, then 1.
- Single-cycle ped_req during GREEN at cur_sec = 5 → after the red expiry tick: ped_ack pulses once, walk = 1 for 60 cycles, car_light = 100, then GREEN with cur_sec = 9.
- ped_req held high through all of PH_WALK → no second walk. The next cycle sequence is GREEN → YELLOW → RED → GREEN.
- enable low for 25 cycles while in YELLOW at cur_sec = 2 → cur_sec stays 2, tick stays 0, and the yellow phase totals 55 cycles.
- rst asserted mid-WALK (cur_sec = 4) → the same cycle shows car_light = 001, walk = 0, cur_sec = 9, and pending cleared. No walk occurs in the following cycle sequence.
- With WALK_FLASH_EN defined → walk is 1 for cur_sec 6..4. For cur_sec 3..1 it is high for prescaler 0–4 and low for 5–9.
